pipe_hazard_ctrl: RTL and testbench

- Hazard control unit for the 5-stage MIPS pipeline.
- Detects load-use hazards, taken branches and multi-cycle multiply occupancy in EX.
- Drives the hold ("remain") and flush controls of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers.
- Keeps saturating stall and flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 86 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hold/flush control for load-use, taken-branch and multi-cycle multiply hazards
// with saturating stall and flush performance counters.
module pipe_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int REG_W   = 5,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_memread_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic             ex_mul_i,
    input  logic             ex_branch_taken_i,
    output logic             pc_remain_o,
    output logic             ifid_remain_o,
    output logic             idex_remain_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             exmem_flush_o,
    output logic             mul_busy_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    typedef enum logic {RUN, MUL_WAIT} state_t;

    localparam logic [7:0] MUL_RELOAD = MUL_LAT > 1 ? 8'(MUL_LAT - 2) : 8'd0;

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_lu;
    logic             w_run;
    logic             w_branch;
    logic             w_mul_hold;
    logic             w_lu_stall;

    assign w_lu = ex_memread_i && (ex_rt_i != '0) &&
                  ((ex_rt_i == id_rs_i) || (id_uses_rt_i && ex_rt_i == id_rt_i));
    assign w_run      = !rst_i && r_state == RUN;
    assign w_branch   = w_run && ex_branch_taken_i;
    // A multiply holds EX either on its first RUN cycle or while the wait count is nonzero.
    assign w_mul_hold = (w_run && !ex_branch_taken_i && ex_mul_i && MUL_LAT > 1) ||
                        (!rst_i && r_state == MUL_WAIT && r_cnt != 8'd0);
    assign w_lu_stall = w_run && !ex_branch_taken_i && !(ex_mul_i && MUL_LAT > 1) && w_lu;

    always_comb begin
        pc_remain_o   = w_mul_hold || w_lu_stall;
        ifid_remain_o = w_mul_hold || w_lu_stall;
        idex_remain_o = w_mul_hold;
        ifid_flush_o  = w_branch;
        idex_flush_o  = w_branch || w_lu_stall;
        exmem_flush_o = w_mul_hold;
        mul_busy_o    = w_mul_hold;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= RUN;
            r_cnt       <= 8'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (pc_remain_o && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_branch && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + 1'b1;
            if (r_state == RUN) begin
                if (w_mul_hold) begin
                    r_state <= MUL_WAIT;
                    r_cnt   <= MUL_RELOAD;
                end
            end else if (r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end else begin
                r_state <= RUN;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random stimulus checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
    localparam int MUL_LAT = 4;
    localparam int REG_W   = 5;
    localparam int CNT_W   = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [REG_W-1:0] id_rs_i, id_rt_i, ex_rt_i;
    logic             id_uses_rt_i, ex_memread_i, ex_mul_i, ex_branch_taken_i;
    logic             pc_remain_o, ifid_remain_o, idex_remain_o;
    logic             ifid_flush_o, idex_flush_o, exmem_flush_o, mul_busy_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

    int errors = 0;
    int checks = 0;
    int mul_left = 0;
    int scnt = 0;
    int fcnt = 0;

    always #5 clk_i = ~clk_i;

    pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i),
        .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i), .ex_mul_i(ex_mul_i),
        .ex_branch_taken_i(ex_branch_taken_i),
        .pc_remain_o(pc_remain_o), .ifid_remain_o(ifid_remain_o), .idex_remain_o(idex_remain_o),
        .ifid_flush_o(ifid_flush_o), .idex_flush_o(idex_flush_o), .exmem_flush_o(exmem_flush_o),
        .mul_busy_o(mul_busy_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Control vector order: pc_remain, ifid_remain, idex_remain, ifid_flush, idex_flush, exmem_flush, mul_busy
    task automatic step(input logic rst, input int rs, input int rt, input logic urt,
                        input logic mr, input int ert, input logic mul, input logic br);
        logic [6:0] e;
        logic       lu;
        @(negedge clk_i);
        rst_i = rst; id_rs_i = REG_W'(rs); id_rt_i = REG_W'(rt); id_uses_rt_i = urt;
        ex_memread_i = mr; ex_rt_i = REG_W'(ert); ex_mul_i = mul; ex_branch_taken_i = br;
        #1;
        lu = mr && ert != 0 && (ert == rs || (urt && ert == rt));
        e = 7'b0;
        if (!rst) begin
            if (mul_left > 0) e = (mul_left > 1) ? 7'b1110011 : 7'b0;
            else if (br) e = 7'b0001100;
            else if (mul && MUL_LAT > 1) e = 7'b1110011;
            else if (lu) e = 7'b1100100;
        end
        check("ctl", {pc_remain_o, ifid_remain_o, idex_remain_o, ifid_flush_o,
                      idex_flush_o, exmem_flush_o, mul_busy_o}, 32'(e));
        check("stall_cnt", 32'(stall_cnt_o), 32'(scnt));
        check("flush_cnt", 32'(flush_cnt_o), 32'(fcnt));
        @(posedge clk_i);
        if (rst) begin
            mul_left = 0; scnt = 0; fcnt = 0;
        end else begin
            if (e[6] && scnt < CMAX) scnt++;
            if (e[3] && fcnt < CMAX) fcnt++;
            if (mul_left > 0) mul_left--;
            else if (!br && mul && MUL_LAT > 1) mul_left = MUL_LAT - 1;
        end
    endtask

    initial begin
        rst_i = 1'b1; id_rs_i = '0; id_rt_i = '0; id_uses_rt_i = 1'b0;
        ex_memread_i = 1'b0; ex_rt_i = '0; ex_mul_i = 1'b0; ex_branch_taken_i = 1'b0;
        repeat (2) @(posedge clk_i);
        step(1, 8, 0, 0, 1, 8, 1, 1);
        step(0, 8, 0, 0, 1, 8, 0, 0);
        step(0, 8, 0, 0, 0, 8, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0, 0);
        step(0, 1, 5, 0, 1, 5, 0, 0);
        step(0, 1, 5, 1, 1, 5, 0, 0);
        step(0, 8, 0, 0, 1, 8, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (6) step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (20) step(0, 3, 0, 0, 1, 3, 0, 0);
        @(negedge clk_i);
        check("stall_sat", 32'(stall_cnt_o), 32'(CMAX));
        repeat (20) step(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(99) < 2, $urandom_range(3), $urandom_range(3), 1'($urandom),
                 $urandom_range(99) < 60, $urandom_range(3), $urandom_range(99) < 12,
                 $urandom_range(99) < 10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
